// File: rtl/main_memory_responder_if.sv
// Main memory request/response bundle between the memory execution element and its responder.
// Latency: none (wires only); response timing is owned by the responder.
// Backpressure: none; the initiator holds its request until it sees the matching ready pulse.
//
// Signals:
//   main_mem_in_addr/_data/_valid  write request (word address, data)
//   main_mem_in_ready              write done, one-cycle pulse
//   main_mem_out_addr/_valid       read request (word address)
//   main_mem_out_data/_ready       read data and read done pulse
//   mem_error                      sticky out-of-range flag
// Modports: master = initiator (memory execution element), slave = responder.

interface main_memory_responder_if;
  logic [31:0] main_mem_in_addr;
  logic [31:0] main_mem_in_data;
  logic        main_mem_in_valid;
  logic        main_mem_in_ready;
  logic [31:0] main_mem_out_addr;
  logic        main_mem_out_valid;
  logic [31:0] main_mem_out_data;
  logic        main_mem_out_ready;
  logic        mem_error;

  modport master (
    output main_mem_in_addr,
    output main_mem_in_data,
    output main_mem_in_valid,
    output main_mem_out_addr,
    output main_mem_out_valid,
    input  main_mem_in_ready,
    input  main_mem_out_data,
    input  main_mem_out_ready,
    input  mem_error
  );

  modport slave (
    input  main_mem_in_addr,
    input  main_mem_in_data,
    input  main_mem_in_valid,
    input  main_mem_out_addr,
    input  main_mem_out_valid,
    output main_mem_in_ready,
    output main_mem_out_data,
    output main_mem_out_ready,
    output mem_error
  );
endinterface

// File: rtl/main_memory_responder.sv
// Main memory responder: services single-word writes and reads against an on-chip word RAM.
// Latency: ready pulses LATENCY cycles after acceptance; one transaction in flight at a time.
// Backpressure: requests are only sampled in IDLE; the initiator holds valid until ready.
//
// Ports:
//   clk    clock (single domain)
//   reset  synchronous, active-high; abandons any request still waiting
//   bus    main_memory_responder_if.slave (write/read requests, ready pulses,
//          read data, sticky mem_error)
// Parameters:
//   ADDR_WIDTH  word-index bits, RAM depth 2^ADDR_WIDTH x 32 (must be < 32)
//   LATENCY     cycles from acceptance to ready, legal range 1..15
// Build option:
//   MAIN_MEM_BOUNDS_CHECK_EN  when defined, addresses with any of bits
//   [31:ADDR_WIDTH] set are out of range: writes are dropped, reads return 0
//   and mem_error is set until reset. When undefined, addresses wrap modulo
//   the RAM depth and mem_error is constant 0.

module main_memory_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  main_memory_responder_if.slave    bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
  localparam logic       LAT_ONE  = (LATENCY == 1);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_data;
  logic [31:0] rd_data_q;
  logic        err_q;

  logic [31:0] mem [DEPTH];

  logic                  req;
  logic                  acc_fire;
  logic                  acc_write;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_data;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic [31-ADDR_WIDTH:0] acc_addr_hi;
  logic                  acc_in_range;

  assign req = bus.main_mem_in_valid | bus.main_mem_out_valid;

  // The RAM access happens on the edge that enters RESP. For LATENCY=1 that
  // is the acceptance edge itself, so the live request is used directly;
  // otherwise it is the last WAIT edge and the latched request is used.
  always_comb begin
    acc_fire  = 1'b0;
    acc_write = lat_write;
    acc_addr  = lat_addr;
    acc_data  = lat_data;
    if (state == ST_IDLE) begin
      // Write wins when both requests arrive together; the read stays pending.
      acc_write = bus.main_mem_in_valid;
      acc_addr  = bus.main_mem_in_valid ? bus.main_mem_in_addr : bus.main_mem_out_addr;
      acc_data  = bus.main_mem_in_data;
      acc_fire  = LAT_ONE & req;
    end else if (state == ST_WAIT) begin
      acc_fire  = (cnt == 4'd1);
    end
  end

  assign acc_idx     = acc_addr[ADDR_WIDTH-1:0];
  assign acc_addr_hi = acc_addr[31:ADDR_WIDTH];

`ifdef MAIN_MEM_BOUNDS_CHECK_EN
  assign acc_in_range = (acc_addr_hi == '0);
`else
  // Upper address bits are ignored: addresses wrap modulo the RAM depth.
  logic unused_addr_hi;
  assign unused_addr_hi = ^acc_addr_hi;
  assign acc_in_range   = 1'b1;
`endif

  // RAM write port. No reset on the array; the reset term only stops a
  // request that reset is abandoning from committing on the same edge.
  always_ff @(posedge clk) begin
    if (!reset && acc_fire && acc_write && acc_in_range) begin
      mem[acc_idx] <= acc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_data  <= '0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      // Read data is held until the next read response; writes leave it alone.
      if (acc_fire && !acc_write) begin
        rd_data_q <= acc_in_range ? mem[acc_idx] : 32'd0;
      end
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
      if (acc_fire && !acc_in_range) begin
        err_q <= 1'b1;
      end
`endif
      case (state)
        ST_IDLE: begin
          if (req) begin
            lat_write <= bus.main_mem_in_valid;
            lat_addr  <= acc_addr;
            lat_data  <= bus.main_mem_in_data;
            cnt       <= CNT_LOAD;
            state     <= LAT_ONE ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // RESP is exactly one cycle, so each ready is a one-cycle pulse and only
  // the one matching the latched kind can be high.
  assign bus.main_mem_in_ready  = (state == ST_RESP) &&  lat_write;
  assign bus.main_mem_out_ready = (state == ST_RESP) && !lat_write;
  assign bus.main_mem_out_data  = rd_data_q;
  assign bus.mem_error          = err_q;

endmodule
